reference_model: RTL and testbench

REFERENCE_MODEL -- requirements
Module: reference_model

---
 rtl/reference_model.sv | 118 +++++++++++
 tb/tb_reference_model.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/reference_model.sv
// Register-access decoder for a four-channel DMA controller: turns CPU read/write
// strobes at a 4-bit address into one-cycle decode pulses and keeps the byte-pointer flip-flop.
module reference_model (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       CS_N,
  input  logic       IOR_N,
  input  logic       IOW_N,
  input  logic [3:0] A,
  input  logic       programCondition,
  output logic       loadCommandReg,
  output logic       loadModeReg,
  output logic       loadRequestReg,
  output logic       loadSingleMask,
  output logic       loadAllMask,
  output logic       clearMask,
  output logic       masterClear,
  output logic       clearInternalFF,
  output logic       loadBaseAddressReg,
  output logic       loadBaseWordCountReg,
  output logic       readStatusReg,
  output logic       readCurrentAddressReg,
  output logic       readCurrentWordCountReg,
  output logic       readTemporaryReg,
  output logic       loadIoDataBufferFromStatus,
  output logic [1:0] channelSelect,
  output logic       internalFF
);

  logic prevIor;
  logic prevIow;
  logic iorArmed;
  logic iowArmed;
  logic selected;
  logic rdStart;
  logic wrStart;

  // A strobe only counts once it has been seen high after reset, so a strobe
  // still held low across reset release cannot fire until it rises and falls again.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      prevIor  <= 1'b1;
      prevIow  <= 1'b1;
      iorArmed <= 1'b0;
      iowArmed <= 1'b0;
    end else begin
      prevIor <= IOR_N;
      prevIow <= IOW_N;
      if (IOR_N) iorArmed <= 1'b1;
      if (IOW_N) iowArmed <= 1'b1;
    end
  end

  assign selected = programCondition & ~CS_N & (IOR_N ^ IOW_N);
  assign rdStart  = selected & ~IOR_N & prevIor & iorArmed;
  assign wrStart  = selected & ~IOW_N & prevIow & iowArmed;

  always_comb begin
    loadCommandReg          = 1'b0;
    loadModeReg             = 1'b0;
    loadRequestReg          = 1'b0;
    loadSingleMask          = 1'b0;
    loadAllMask             = 1'b0;
    clearMask               = 1'b0;
    masterClear             = 1'b0;
    clearInternalFF         = 1'b0;
    loadBaseAddressReg      = 1'b0;
    loadBaseWordCountReg    = 1'b0;
    readStatusReg           = 1'b0;
    readCurrentAddressReg   = 1'b0;
    readCurrentWordCountReg = 1'b0;
    readTemporaryReg        = 1'b0;
    if (wrStart) begin
      if (!A[3]) begin
        loadBaseWordCountReg = A[0];
        loadBaseAddressReg   = ~A[0];
      end else begin
        case (A[2:0])
          3'd0:    loadCommandReg  = 1'b1;
          3'd1:    loadRequestReg  = 1'b1;
          3'd2:    loadSingleMask  = 1'b1;
          3'd3:    loadModeReg     = 1'b1;
          3'd4:    clearInternalFF = 1'b1;
          3'd5:    masterClear     = 1'b1;
          3'd6:    clearMask       = 1'b1;
          default: loadAllMask     = 1'b1;
        endcase
      end
    end
    if (rdStart) begin
      if (!A[3]) begin
        readCurrentWordCountReg = A[0];
        readCurrentAddressReg   = ~A[0];
      end else begin
        readStatusReg    = (A[2:0] == 3'd0);
        readTemporaryReg = (A[2:0] == 3'd5);
      end
    end
  end

  assign channelSelect = A[2:1];

  // Clear wins over toggle; only channel register accesses (A < 8) move the pointer.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      internalFF                 <= 1'b0;
      loadIoDataBufferFromStatus <= 1'b0;
    end else begin
      loadIoDataBufferFromStatus <= readStatusReg;
      if (clearInternalFF || masterClear) begin
        internalFF <= 1'b0;
      end else if ((rdStart || wrStart) && !A[3]) begin
        internalFF <= ~internalFF;
      end
    end
  end

endmodule

// File: tb/tb_reference_model.sv
// Bench for reference_model: directed register-access scenarios with literal
// expectations, then randomized bus activity checked against a behavioural model.
module tb_reference_model;

  logic       CLK;
  logic       RESET_N;
  logic       CS_N;
  logic       IOR_N;
  logic       IOW_N;
  logic [3:0] A;
  logic       programCondition;
  logic       loadCommandReg, loadModeReg, loadRequestReg, loadSingleMask, loadAllMask;
  logic       clearMask, masterClear, clearInternalFF, loadBaseAddressReg, loadBaseWordCountReg;
  logic       readStatusReg, readCurrentAddressReg, readCurrentWordCountReg, readTemporaryReg;
  logic       loadIoDataBufferFromStatus;
  logic [1:0] channelSelect;
  logic       internalFF;

  reference_model dut (
    .CLK(CLK), .RESET_N(RESET_N), .CS_N(CS_N), .IOR_N(IOR_N), .IOW_N(IOW_N), .A(A),
    .programCondition(programCondition),
    .loadCommandReg(loadCommandReg), .loadModeReg(loadModeReg), .loadRequestReg(loadRequestReg),
    .loadSingleMask(loadSingleMask), .loadAllMask(loadAllMask), .clearMask(clearMask),
    .masterClear(masterClear), .clearInternalFF(clearInternalFF),
    .loadBaseAddressReg(loadBaseAddressReg), .loadBaseWordCountReg(loadBaseWordCountReg),
    .readStatusReg(readStatusReg), .readCurrentAddressReg(readCurrentAddressReg),
    .readCurrentWordCountReg(readCurrentWordCountReg), .readTemporaryReg(readTemporaryReg),
    .loadIoDataBufferFromStatus(loadIoDataBufferFromStatus),
    .channelSelect(channelSelect), .internalFF(internalFF)
  );

  // Strobe vector, bit order: 0 command, 1 mode, 2 request, 3 single mask, 4 all mask,
  // 5 clear mask, 6 master clear, 7 clear FF, 8 base addr, 9 base count,
  // 10 status, 11 current addr, 12 current count, 13 temporary.
  logic [13:0] dutVec;
  assign dutVec = {readTemporaryReg, readCurrentWordCountReg, readCurrentAddressReg, readStatusReg,
                   loadBaseWordCountReg, loadBaseAddressReg, clearInternalFF, masterClear,
                   clearMask, loadAllMask, loadSingleMask, loadRequestReg, loadModeReg,
                   loadCommandReg};

  int checks = 0;
  int errors = 0;
  bit compareOn = 0;

  // clock/reset block
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: last observed level of each strobe (0 after reset = not yet seen high)
  bit mLastIor, mLastIow, mFF, mLoadBuf;

  function automatic bit wrEdge();
    return RESET_N && programCondition && !CS_N && !IOW_N && IOR_N && mLastIow;
  endfunction

  function automatic bit rdEdge();
    return RESET_N && programCondition && !CS_N && !IOR_N && IOW_N && mLastIor;
  endfunction

  function automatic logic [13:0] expDecode(input bit rd, input bit wr, input logic [3:0] a);
    logic [13:0] v;
    int addr;
    v = '0;
    addr = int'(a);
    if (wr) begin
      if (addr < 8) v[(addr % 2 == 1) ? 9 : 8] = 1'b1;
      else case (addr)
        8: v[0] = 1'b1;   9: v[2] = 1'b1;  10: v[3] = 1'b1;  11: v[1] = 1'b1;
        12: v[7] = 1'b1; 13: v[6] = 1'b1;  14: v[5] = 1'b1;  15: v[4] = 1'b1;
        default: ;
      endcase
    end
    if (rd) begin
      if (addr < 8) v[(addr % 2 == 1) ? 12 : 11] = 1'b1;
      else if (addr == 8) v[10] = 1'b1;
      else if (addr == 13) v[13] = 1'b1;
    end
    return v;
  endfunction

  always @(negedge RESET_N) begin
    mLastIor = 0; mLastIow = 0; mFF = 0; mLoadBuf = 0;
  end

  always @(posedge CLK) begin
    bit rd, wr;
    if (!RESET_N) begin
      mLastIor = 0; mLastIow = 0; mFF = 0; mLoadBuf = 0;
    end else begin
      rd = rdEdge();
      wr = wrEdge();
      mLoadBuf = rd && (A == 4'd8);
      if (wr && (A == 4'd12 || A == 4'd13)) mFF = 0;
      else if ((rd || wr) && A < 4'd8) mFF = ~mFF;
      mLastIor = IOR_N;
      mLastIow = IOW_N;
    end
  end

  // scoreboard: one compare per meaningful output every cycle
  always @(negedge CLK) begin
    if (compareOn) begin
      check("strobes", 32'(dutVec), 32'(expDecode(rdEdge(), wrEdge(), A)));
      check("onehot", 32'($countones(dutVec) <= 1), 32'd1);
      check("loadBuf", 32'(loadIoDataBufferFromStatus), 32'(mLoadBuf));
      check("internalFF", 32'(internalFF), 32'(mFF));
      check("chanSel", 32'(channelSelect), 32'(A[2:1]));
    end
  end

  // driver tasks
  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
    #1;
  endtask

  task automatic drive(input logic pc, input logic cs, input logic rdn, input logic wrn,
                       input logic [3:0] a);
    nextCycle();
    programCondition = pc; CS_N = cs; IOR_N = rdn; IOW_N = wrn; A = a;
  endtask

  initial begin
    RESET_N = 1'b0; CS_N = 1'b1; IOR_N = 1'b1; IOW_N = 1'b1; A = 4'd0; programCondition = 1'b0;
    #2 compareOn = 1;
    mid();
    check("rst_strobes", 32'(dutVec), 32'd0);
    check("rst_ff", 32'(internalFF), 32'd0);
    check("rst_buf", 32'(loadIoDataBufferFromStatus), 32'd0);
    nextCycle();
    RESET_N = 1'b1;
    repeat (3) nextCycle();
    mid();
    check("idle_strobes", 32'(dutVec), 32'd0);
    check("idle_ff", 32'(internalFF), 32'd0);

    // held write at command register
    drive(1, 0, 1, 0, 4'd8); mid(); check("cmd_first", 32'(dutVec), 32'h0001);
    drive(1, 0, 1, 0, 4'd8); mid(); check("cmd_held1", 32'(dutVec), 32'h0000);
    drive(1, 0, 1, 0, 4'd8); mid(); check("cmd_held2", 32'(dutVec), 32'h0000);
    drive(1, 0, 1, 1, 4'd8);

    // status read then buffer transfer
    drive(1, 0, 0, 1, 4'd8); mid();
    check("status_n", 32'(dutVec), 32'h0400);
    check("buf_n", 32'(loadIoDataBufferFromStatus), 32'd0);
    drive(1, 0, 1, 1, 4'd8); mid();
    check("status_n1", 32'(dutVec), 32'h0000);
    check("buf_n1", 32'(loadIoDataBufferFromStatus), 32'd1);

    // two base-address writes on channel 1
    drive(1, 0, 1, 0, 4'd2); mid();
    check("base_1", 32'(dutVec), 32'h0100);
    check("chan_1", 32'(channelSelect), 32'd1);
    drive(1, 0, 1, 1, 4'd2); mid(); check("ff_after1", 32'(internalFF), 32'd1);
    drive(1, 0, 1, 0, 4'd2); mid(); check("base_2", 32'(dutVec), 32'h0100);
    drive(1, 0, 1, 1, 4'd2); mid(); check("ff_after2", 32'(internalFF), 32'd0);

    // word count write then clear flip-flop
    drive(1, 0, 1, 0, 4'd1); mid(); check("wc_1", 32'(dutVec), 32'h0200);
    drive(1, 0, 1, 1, 4'd1); mid(); check("ff_wc", 32'(internalFF), 32'd1);
    drive(1, 0, 1, 0, 4'd12); mid(); check("clrff", 32'(dutVec), 32'h0080);
    drive(1, 0, 1, 1, 4'd12); mid(); check("ff_cleared", 32'(internalFF), 32'd0);

    // no decode outside program mode; both strobes low is ignored
    drive(0, 0, 1, 0, 4'd11); mid(); check("mode_noprog", 32'(dutVec), 32'h0000);
    drive(0, 0, 1, 1, 4'd11);
    drive(1, 0, 1, 0, 4'd0);
    drive(1, 0, 1, 1, 4'd0); mid(); check("ff_pre_both", 32'(internalFF), 32'd1);
    drive(1, 0, 0, 0, 4'd0); mid(); check("both_low", 32'(dutVec), 32'h0000);
    drive(1, 0, 1, 1, 4'd0); mid(); check("ff_both_hold", 32'(internalFF), 32'd1);

    // reset in the middle of an access
    drive(1, 0, 1, 0, 4'd0); mid(); check("pre_rst_pulse", 32'(dutVec), 32'h0100);
    RESET_N = 1'b0;
    #1;
    check("midrst_strobes", 32'(dutVec), 32'd0);
    check("midrst_ff", 32'(internalFF), 32'd0);
    nextCycle();
    RESET_N = 1'b1;
    mid(); check("post_rst_held", 32'(dutVec), 32'h0000);
    drive(1, 0, 1, 0, 4'd0); mid(); check("post_rst_held2", 32'(dutVec), 32'h0000);
    drive(1, 0, 1, 1, 4'd0);
    drive(1, 0, 1, 0, 4'd0); mid(); check("post_rst_refall", 32'(dutVec), 32'h0100);
    drive(1, 0, 1, 1, 4'd0);

    // randomized bus activity
    for (int i = 0; i < 600; i++) begin
      nextCycle();
      if ($urandom_range(0, 199) == 0) begin
        RESET_N = 1'b0;
        nextCycle();
        RESET_N = 1'b1;
      end
      programCondition = ($urandom_range(0, 9) != 0);
      CS_N  = ($urandom_range(0, 9) == 0);
      IOR_N = ($urandom_range(0, 2) != 0);
      IOW_N = ($urandom_range(0, 2) != 0);
      A     = 4'($urandom_range(0, 15));
    end
    nextCycle();
    mid();
    compareOn = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
